// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - RV32I opcode constants and immediate format codes shared by decode logic
package riscv_pkg;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Immediate format codes; 6 and 7 are never produced
    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

endpackage

// File: rtl/imm_fmt_decode.sv
// rtl/imm_fmt_decode.sv - maps a 7-bit major opcode to its immediate format
module imm_fmt_decode
    import riscv_pkg::*;
(
    input  logic [6:0] opcode_i,
    output imm_fmt_e   fmt_o
);

    // Opcode lookup; funct fields never influence the format
    always_comb begin
        fmt_o = IMM_NONE;
        case (opcode_i)
            OPC_LOAD,
            OPC_MISC_MEM,
            OPC_OP_IMM,
            OPC_JALR,
            OPC_SYSTEM:   fmt_o = IMM_I;
            OPC_STORE:    fmt_o = IMM_S;
            OPC_BRANCH:   fmt_o = IMM_B;
            OPC_LUI,
            OPC_AUIPC:    fmt_o = IMM_U;
            OPC_JAL:      fmt_o = IMM_J;
            default:      fmt_o = IMM_NONE;
        endcase
    end

endmodule

// File: rtl/riscv_imm_gen.sv
// rtl/riscv_imm_gen.sv - RV32I immediate generator with sticky no-immediate flag; IMM_GEN_OUT_REG_EN registers the outputs
module riscv_imm_gen
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic [31:0] imm_out,
    output logic [2:0]  imm_fmt,
    output logic        no_imm,
    output logic        err_sticky
);

    imm_fmt_e    fmt_c;
    logic [31:0] imm_c;
    logic        no_imm_c;
    logic        err_set;
    logic        err_sticky_q;
    logic        err_sticky_d;

    imm_fmt_decode u_fmt_decode (
        .opcode_i (instr[6:0]),
        .fmt_o    (fmt_c)
    );

    assign no_imm_c = (fmt_c == IMM_NONE);

    // Assemble the immediate; the sign always comes from instr[31]
    always_comb begin
        imm_c = 32'd0;
        case (fmt_c)
            IMM_I:   imm_c = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm_c = {instr[31:12], 12'd0};
            IMM_J:   imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm_c = 32'd0;
        endcase
    end

`ifdef IMM_GEN_OUT_REG_EN
    logic [31:0] imm_q;
    logic [2:0]  fmt_q;
    logic        no_imm_q;
    logic        valid_q;

    // Output pipeline stage; valid is delayed alongside so the sticky flag sees aligned data
    always_ff @(posedge clk) begin
        if (rst) begin
            imm_q    <= 32'd0;
            fmt_q    <= 3'd0;
            no_imm_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            imm_q    <= imm_c;
            fmt_q    <= fmt_c;
            no_imm_q <= no_imm_c;
            valid_q  <= instr_valid;
        end
    end

    assign imm_out = imm_q;
    assign imm_fmt = fmt_q;
    assign no_imm  = no_imm_q;
    assign err_set = valid_q & no_imm_q;
`else
    assign imm_out = imm_c;
    assign imm_fmt = fmt_c;
    assign no_imm  = no_imm_c;
    assign err_set = instr_valid & no_imm_c;
`endif

    assign err_sticky_d = err_sticky_q | err_set;

    // Sticky error flag; reset wins over a same-cycle set
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_riscv_imm_gen.sv
// tb/tb_riscv_imm_gen.sv - randomized self-checking bench for riscv_imm_gen, either build of IMM_GEN_OUT_REG_EN
module tb_riscv_imm_gen;

    logic        clk;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] imm_out;
    logic [2:0]  imm_fmt;
    logic        no_imm;
    logic        err_sticky;

    int n_vec;
    int n_bad;

    logic err_m;
`ifdef IMM_GEN_OUT_REG_EN
    logic valid_m;
    logic noimm_m;
`endif

    riscv_imm_gen dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .imm_out     (imm_out),
        .imm_fmt     (imm_fmt),
        .no_imm      (no_imm),
        .err_sticky  (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: field values weighted by their bit positions, sign as a negative weight
    function automatic void ref_imm(input logic [31:0] w, output logic [31:0] imm, output logic [2:0] fmt);
        int v;
        v   = 0;
        fmt = 3'd0;
        case (w[6:0])
            7'b0000011, 7'b0001111, 7'b0010011, 7'b1100111, 7'b1110011: begin
                fmt = 3'd1;
                v = int'(w[30:20]) - (w[31] ? 2048 : 0);
            end
            7'b0100011: begin
                fmt = 3'd2;
                v = int'(w[30:25]) * 32 + int'(w[11:7]) - (w[31] ? 2048 : 0);
            end
            7'b1100011: begin
                fmt = 3'd3;
                v = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2 - (w[31] ? 4096 : 0);
            end
            7'b0110111, 7'b0010111: begin
                fmt = 3'd4;
                v = int'(w & 32'hFFFF_F000);
            end
            7'b1101111: begin
                fmt = 3'd5;
                v = int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2 - (w[31] ? 1048576 : 0);
            end
            default: v = 0;
        endcase
        imm = 32'(v);
    endfunction

    function automatic logic ref_noimm(input logic [31:0] w);
        logic [31:0] i;
        logic [2:0]  f;
        ref_imm(w, i, f);
        return (f == 3'd0);
    endfunction

    // Sticky-flag reference, updated on each rising edge from the applied stimulus
    always @(posedge clk) begin
`ifdef IMM_GEN_OUT_REG_EN
        if (rst) begin
            err_m   = 1'b0;
            valid_m = 1'b0;
            noimm_m = 1'b0;
        end else begin
            if (valid_m && noimm_m) err_m = 1'b1;
            valid_m = instr_valid;
            noimm_m = ref_noimm(instr);
        end
`else
        if (rst) err_m = 1'b0;
        else if (instr_valid && ref_noimm(instr)) err_m = 1'b1;
`endif
    end

    // One clock of stimulus; immediate outputs checked against exp_imm/exp_fmt
    task automatic cycle(input logic [31:0] w, input logic v, input logic r,
                         input logic [31:0] exp_imm, input logic [2:0] exp_fmt);
        @(negedge clk);
        instr       = w;
        instr_valid = v;
        rst         = r;
`ifndef IMM_GEN_OUT_REG_EN
        #1;
        check("imm_out", imm_out, exp_imm);
        check("imm_fmt", 32'(imm_fmt), 32'(exp_fmt));
        check("no_imm", 32'(no_imm), 32'(exp_fmt == 3'd0));
        @(posedge clk);
        #1;
`else
        @(posedge clk);
        #1;
        check("imm_out_reg", imm_out, r ? 32'd0 : exp_imm);
        check("imm_fmt_reg", 32'(imm_fmt), r ? 32'd0 : 32'(exp_fmt));
        check("no_imm_reg", 32'(no_imm), r ? 32'd0 : 32'(exp_fmt == 3'd0));
`endif
        check("err_sticky", 32'(err_sticky), 32'(err_m));
    endtask

    task automatic rcycle(input logic [31:0] w, input logic v, input logic r);
        logic [31:0] ei;
        logic [2:0]  ef;
        ref_imm(w, ei, ef);
        cycle(w, v, r, ei, ef);
    endtask

    logic [6:0] opc_tab [12];

    initial begin
        n_vec       = 0;
        n_bad       = 0;
        err_m       = 1'b0;
        rst         = 1'b1;
        instr       = 32'd0;
        instr_valid = 1'b0;
        opc_tab = '{7'b0000011, 7'b0001111, 7'b0010011, 7'b0010111, 7'b0100011, 7'b0110011,
                    7'b0110111, 7'b1100011, 7'b1100111, 7'b1101111, 7'b1110011, 7'b0000000};

        // Reset, then directed vectors with literal expectations
        cycle(32'h0050_0093, 1'b1, 1'b1, 32'h0000_0005, 3'd1);
        check("err_after_reset", 32'(err_sticky), 32'd0);
        cycle(32'h0050_0093, 1'b1, 1'b0, 32'h0000_0005, 3'd1);
        cycle(32'h0011_2423, 1'b1, 1'b0, 32'h0000_0008, 3'd2);
        cycle(32'hFE20_8EE3, 1'b1, 1'b0, 32'hFFFF_FFFC, 3'd3);
        cycle(32'h1234_50B7, 1'b1, 1'b0, 32'h1234_5000, 3'd4);
        cycle(32'h0100_00EF, 1'b1, 1'b0, 32'h0000_0010, 3'd5);
        cycle(32'h8000_0093, 1'b1, 1'b0, 32'hFFFF_F800, 3'd1);
        cycle(32'hFFFF_F0EF, 1'b1, 1'b0, 32'hFFFF_FFFE, 3'd5);
        cycle(32'hFFFF_F097, 1'b1, 1'b0, 32'hFFFF_F000, 3'd4);
        check("err_still_clear", 32'(err_sticky), 32'd0);

        // No-immediate opcode: invalid first (no set), then valid (set), then hold
        cycle(32'h0031_00B3, 1'b0, 1'b0, 32'd0, 3'd0);
        cycle(32'h0050_0093, 1'b1, 1'b0, 32'h0000_0005, 3'd1);
        cycle(32'h0031_00B3, 1'b1, 1'b0, 32'd0, 3'd0);
        for (int i = 0; i < 3; i++) cycle(32'h0050_0093, 1'b1, 1'b0, 32'h0000_0005, 3'd1);
        check("err_set_held", 32'(err_sticky), 32'd1);

        // Reset coinciding with a set condition clears the flag
        cycle(32'h0031_00B3, 1'b1, 1'b1, 32'd0, 3'd0);
        check("err_rst_priority", 32'(err_sticky), 32'd0);
        cycle(32'h0050_0093, 1'b1, 1'b0, 32'h0000_0005, 3'd1);
        cycle(32'h0050_0093, 1'b1, 1'b0, 32'h0000_0005, 3'd1);
        check("err_after_rst_clear", 32'(err_sticky), 32'd0);

        // Random instructions, mostly known opcodes, with occasional resets
        for (int i = 0; i < 400; i++) begin
            logic [31:0] w;
            int          k;
            w = $urandom();
            k = $urandom_range(0, 12);
            if (k < 12) w[6:0] = opc_tab[k];
            rcycle(w, ($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_imm_gen.md
# riscv_imm_gen

RV32I immediate generator for the decode stage. Takes the 32-bit instruction word, selects the immediate format from the opcode, and produces the assembled, sign-extended 32-bit immediate for the ALU operand mux, branch/jump target adder and load/store address path. It also reports the decoded format, and flags opcodes that carry no immediate through a combinational flag and a registered sticky error flag.

## Interface
- No parameters.
- One clock; reset is synchronous and active-high.
- `clk`: input, 1 bit. Core clock; the only clock in the block.
- `rst`: input, 1 bit. Synchronous active-high reset.
- `instr`: input, 32 bits. Instruction word, fetched or decode-stage.
- `instr_valid`: input, 1 bit. Qualifies `instr`; used only by the sticky error flag.
- `imm_out`: output, 32 bits. Sign-extended immediate.
- `imm_fmt`: output, 3 bits. Decoded format code.
- `no_imm`: output, 1 bit. Combinational: opcode has no immediate format.
- `err_sticky`: output, 1 bit. Registered: a valid instruction with no immediate format has been seen since reset.

## Operation
Format is selected by `instr[6:0]`:
- **I** (`imm_fmt`=1): opcodes 0000011 LOAD, 0001111 MISC-MEM, 0010011 OP-IMM, 1100111 JALR, 1110011 SYSTEM.
  - `imm_out` = sext(`instr[31:20]`).
  - Shift-immediates use the same rule; the ALU uses only bits [4:0].
- **S** (`imm_fmt`=2): opcode 0100011.
  - `imm_out` = sext({`instr[31:25]`, `instr[11:7]`}).
- **B** (`imm_fmt`=3): opcode 1100011.
  - `imm_out` = sext({`instr[31]`, `instr[7]`, `instr[30:25]`, `instr[11:8]`, 1'b0}).
- **U** (`imm_fmt`=4): opcodes 0110111 LUI and 0010111 AUIPC.
  - `imm_out` = {`instr[31:12]`, 12'b0}.
- **J** (`imm_fmt`=5): opcode 1101111.
  - `imm_out` = sext({`instr[31]`, `instr[19:12]`, `instr[20]`, `instr[30:21]`, 1'b0}).
- **Any other opcode**, including 0110011 OP: `imm_fmt`=0, `imm_out`=0, `no_imm`=1.
- Sign bit is always `instr[31]`. B and J immediates are always even.
- `imm_fmt` codes 6 and 7 are never produced.
- Only `instr[6:0]` affects format selection; funct3/funct7 are ignored.

## Timing
- `imm_out`, `imm_fmt`, `no_imm`: combinational from `instr` with zero latency (default build, no macro). They are valid in the same cycle `instr` is stable.
- `err_sticky`:
  - Cleared to 0 on a rising `clk` with `rst`=1.
  - Otherwise set to 1 on a rising `clk` with `instr_valid`=1 and `no_imm`=1.
  - Holds until the next reset. `rst` has priority over a simultaneous set.
- Reset values: `err_sticky`=0. Combinational outputs are unaffected by reset in the default build.

## Configuration
- Macro `IMM_GEN_OUT_REG_EN`.
- **Defined:**
  - `imm_out`, `imm_fmt` and `no_imm` are registered on rising `clk`, giving one-cycle latency from `instr`.
  - `rst` drives them to 0, 0 and 0.
  - `err_sticky` then uses the registered `no_imm` and a one-cycle-delayed `instr_valid`. Asserting `rst` clears these pipeline registers as well.
- **Undefined:** fully combinational outputs as above.

## Structure
- Shared package `riscv_pkg` holds:
  - The 7-bit opcode constants (LOAD, MISC_MEM, OP_IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, SYSTEM).
  - The `imm_fmt_e` enum: NONE=0, I=1, S=2, B=3, U=4, J=5.
- One sub-module is natural: `imm_fmt_decode`, mapping opcode to `imm_fmt_e`. Immediate assembly and the sticky flag stay in the top.

## Test plan
- ADDI x1,x0,5, `instr`=0x00500093 -> `imm_out`=5, `imm_fmt`=1, `no_imm`=0.
- SW x1,8(x2), 0x00112423 -> `imm_out`=8, `imm_fmt`=2. BEQ x1,x2,-4, 0xFE208EE3 -> `imm_out`=0xFFFFFFFC, `imm_fmt`=3.
- LUI x1,0x12345, 0x123450B7 -> `imm_out`=0x12345000, `imm_fmt`=4. JAL x1,16, 0x010000EF -> `imm_out`=16, `imm_fmt`=5.
- Sign extremes:
  - ADDI with imm -2048, 0x80000093 -> 0xFFFFF800.
  - JAL imm -2, 0xFFFFF0EF -> 0xFFFFFFFE.
  - AUIPC 0xFFFFF, 0xFFFFF097 -> 0xFFFFF000.
- ADD x1,x2,x3, 0x003100B3, `instr_valid`=1 -> `imm_out`=0 and `no_imm`=1. `err_sticky` rises after the clock edge and stays 1 with valid I-type instructions following. `rst`=1 -> `err_sticky`=0 on the next edge, including when the set condition occurs in the same cycle.
- With `IMM_GEN_OUT_REG_EN`:
  - Apply the instruction sequence above: each expected value appears exactly one cycle later.
  - Assert `rst` mid-sequence: all outputs read 0 after that edge.
